// File: rtl/serial_frame_deserializer_pkg.sv
// serdes_pkg: shared types and constants for the serial frame deserializer.
// Optional even-parity trailer bit is enabled by PARITY_CHECK_EN.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  localparam int PARITY_BITS = 1;

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Parallel valid/ready word interface of the deserializer.
// master drives the word, slave consumes it.
interface serial_frame_deserializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;

  modport master (
    output par_data,
    output par_valid,
    input  par_ready
  );

  modport slave (
    input  par_data,
    input  par_valid,
    output par_ready
  );

endinterface

// File: rtl/serial_frame_deserializer.sv
// Framed serial-to-parallel receiver with one-entry holding register.
// Define PARITY_CHECK_EN to require a trailing even-parity bit per frame.
module serial_frame_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sin_valid,
  input  logic sin_data,
  input  logic sin_frame,
  input  logic msb_first,
  input  logic clear_err,
  serial_frame_deserializer_if.master par,
  output logic busy,
  output logic overrun,
  output logic frame_err,
  output logic parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic             frame_stb;
  logic             data_stb;
  logic             last_bit;
  logic             frame_evt;
  logic             complete;
  logic             par_ok;
  logic             hold_free;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] word;

  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] s,
    input logic             d,
    input logic             b
  );
    return (d == DIR_MSB_FIRST) ? {s[WIDTH-2:0], b}
                                : {b, s[WIDTH-1:1]};
  endfunction

  assign frame_stb = sin_valid && sin_frame;
  assign data_stb  = sin_valid && !sin_frame;
  assign last_bit  = (state_q == SHIFT) && data_stb
                  && (cnt_q == CW'(WIDTH - 1));
  assign frame_evt = frame_stb && (state_q != IDLE);
  assign hold_free = !valid_q || par.par_ready;

`ifdef PARITY_CHECK_EN
  logic par_evt;
  assign complete = (state_q == PARITY) && data_stb;
  assign word     = sreg_q;
  // Even parity: data bits plus parity bit hold an even count of ones.
  assign par_ok   = ~^{sreg_q, sin_data};
  assign par_evt  = complete && !par_ok;
`else
  assign complete = last_bit;
  assign word     = shift_in(sreg_q, dir_q, sin_data);
  assign par_ok   = 1'b1;
`endif

  assign accept = complete && par_ok && hold_free;
  assign drop   = complete && par_ok && !hold_free;

  assign par.par_data  = data_q;
  assign par.par_valid = valid_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; a frame bit mid-word restarts in SHIFT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_stb) state_d = SHIFT;
      end
      SHIFT: begin
`ifdef PARITY_CHECK_EN
        if (last_bit) state_d = PARITY;
`else
        if (last_bit) state_d = IDLE;
`endif
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (frame_stb)     state_d = SHIFT;
        else if (complete) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy while any part of a frame is outstanding
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Shift register, bit counter and latched bit order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_LSB_FIRST;
    end else if (frame_stb) begin
      sreg_q <= shift_in('0, msb_first, sin_data);
      cnt_q  <= CW'(1);
      dir_q  <= msb_first;
    end else if (data_stb && state_q == SHIFT) begin
      sreg_q <= shift_in(sreg_q, dir_q, sin_data);
      cnt_q  <= last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  // Holding register; a new word in the consume cycle keeps valid high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= word;
      valid_q <= 1'b1;
    end else if (valid_q && par.par_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky error flags; a same-cycle event beats clear_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun && !clear_err) || drop;
      frame_err <= (frame_err && !clear_err) || frame_evt;
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky parity error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= (parity_err && !clear_err) || par_evt;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer (WIDTH=8).
// Parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_frame_deserializer;

  logic clk = 1'b0;
  logic reset;
  logic sin_valid, sin_data, sin_frame;
  logic msb_first, clear_err;
  logic busy, overrun, frame_err, parity_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_frame_deserializer_if #(.WIDTH(8)) pif ();

  serial_frame_deserializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .sin_frame (sin_frame),
    .msb_first (msb_first),
    .clear_err (clear_err),
    .par       (pif),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic       msb;
    int         gmax;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic d, input logic f,
                          input logic m, input logic rdy);
    sin_valid = 1'b1;
    sin_data  = d;
    sin_frame = f;
    msb_first = m;
    pif.par_ready = rdy;
    tick();
    sin_valid = 1'b0;
    sin_frame = 1'b0;
    pif.par_ready = 1'b0;
  endtask

  // tx[7] goes out first; msb_first flips after the frame bit
  task automatic send_word(input logic [7:0] tx, input logic msb,
                           input int gmax, input logic rdy_last,
                           input logic pflip);
    logic last_rdy;
    for (int k = 0; k < 8; k++) begin
      last_rdy = 1'b0;
`ifndef PARITY_CHECK_EN
      if (k == 7) last_rdy = rdy_last;
`endif
      send_bit(tx[7-k], k == 0, (k == 0) ? msb : !msb, last_rdy);
      if (k < 7) repeat (k % (gmax + 1)) tick();
    end
`ifdef PARITY_CHECK_EN
    send_bit((^tx) ^ pflip, 1'b0, !msb, rdy_last);
`else
    if (pflip) $display("parity flip ignored");
`endif
  endtask

  task automatic consume();
    pif.par_ready = 1'b1;
    tick();
    pif.par_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hB2, 1'b1, 0, 8'hB2};
    vecs[1] = '{8'hB2, 1'b0, 0, 8'h4D};
    vecs[2] = '{8'hB2, 1'b0, 3, 8'h4D};
    vecs[3] = '{8'hB2, 1'b0, 2, 8'h4D};
    vecs[4] = '{8'hF0, 1'b0, 1, 8'h0F};
    vecs[5] = '{8'h01, 1'b0, 0, 8'h80};
    vecs[6] = '{8'h80, 1'b1, 3, 8'h80};

    reset = 1'b1;
    sin_valid = 1'b0;
    sin_data = 1'b0;
    sin_frame = 1'b0;
    msb_first = 1'b0;
    clear_err = 1'b0;
    pif.par_ready = 1'b0;
    repeat (2) tick();
    chk("rst_data", pif.par_data, 8'h00);
    chk("rst_valid", pif.par_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    reset = 1'b0;
    tick();

    // Unframed bits in IDLE are ignored
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_valid", pif.par_valid, 0);

    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].tx, vecs[i].msb, vecs[i].gmax, 1'b0, 1'b0);
      chk($sformatf("vec%0d_data", i), pif.par_data, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), pif.par_valid, 1);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      consume();
      chk($sformatf("vec%0d_drain", i), pif.par_valid, 0);
    end

    // Overrun with a full holding register
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    chk("ovr_first", pif.par_data, 8'hA5);
    send_word(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    chk("ovr_hold", pif.par_data, 8'hA5);
    chk("ovr_valid", pif.par_valid, 1);
    chk("ovr_flag", overrun, 1);
    consume();
    chk("ovr_drain", pif.par_valid, 0);
    chk("ovr_sticky", overrun, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovr_clear", overrun, 0);

    // Consume in the completion cycle: no overrun
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1, 0, 1'b1, 1'b0);
    chk("pulse_data", pif.par_data, 8'h3C);
    chk("pulse_valid", pif.par_valid, 1);
    chk("pulse_ovr", overrun, 0);
    consume();
    chk("pulse_drain", pif.par_valid, 0);

    // Frame bit after 3 bits, then a clean word
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fe_busy", busy, 1);
    chk("fe_none_yet", frame_err, 0);
    send_word(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    chk("fe_flag", frame_err, 1);
    chk("fe_data", pif.par_data, 8'h5A);
    chk("fe_valid", pif.par_valid, 1);
    consume();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("fe_clear", frame_err, 0);

    // Error event wins over clear_err in the same cycle
    send_bit(1'b0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    clear_err = 1'b1;
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    clear_err = 1'b0;
    chk("fe_vs_clear", frame_err, 1);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_busy", busy, 1);

    // Asynchronous reset mid-word
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", pif.par_valid, 0);
    chk("arst_data", pif.par_data, 8'h00);
    chk("arst_frame_err", frame_err, 0);
    chk("arst_overrun", overrun, 0);
    tick();
    reset = 1'b0;
    tick();
    send_word(8'hC3, 1'b1, 1, 1'b0, 1'b0);
    chk("post_rst_data", pif.par_data, 8'hC3);
    chk("post_rst_valid", pif.par_valid, 1);
    chk("post_rst_fe", frame_err, 0);
    consume();

`ifdef PARITY_CHECK_EN
    send_word(8'hB2, 1'b1, 0, 1'b0, 1'b0);
    chk("par_ok_valid", pif.par_valid, 1);
    chk("par_ok_data", pif.par_data, 8'hB2);
    chk("par_ok_flag", parity_err, 0);
    consume();
    send_word(8'hB2, 1'b1, 0, 1'b0, 1'b1);
    chk("par_bad_valid", pif.par_valid, 0);
    chk("par_bad_flag", parity_err, 1);
    chk("par_bad_busy", busy, 0);
`else
    chk("par_tied", parity_err, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
